// File: rtl/dtcm_responder.sv
// dtcm_responder: responder end of the memory-stage data request protocol,
// backed by a single-port, word-organised tightly-coupled data memory.
// One transaction in flight; writes merge sub-words via byte enables, reads
// return the whole aligned word, and faulting accesses raise err_o.
// Optional build macro: DTCM_PARITY_EN adds one even-parity bit per byte
// lane, the inject_par_err_i test input and parity checking on reads.
// XLEN must equal dtcm_pkg::DTCM_XLEN because the request/response structs
// are declared with the package width.

package dtcm_pkg;
    localparam int DTCM_XLEN = 32;

    typedef enum logic [1:0] {
        NO_SIZE = 2'd0,
        BYTE    = 2'd1,
        HALF    = 2'd2,
        WORD    = 2'd3
    } mem_size_t;

    typedef struct packed {
        logic                 valid;
        logic [DTCM_XLEN-1:0] addr;
        logic                 ready;
        logic                 rw;
        mem_size_t            rw_size;
        logic [DTCM_XLEN-1:0] data;
        logic                 uncached;
    } dcache_req_t;

    typedef struct packed {
        logic                 valid;
        logic                 ready;
        logic [DTCM_XLEN-1:0] data;
    } dcache_res_t;
endpackage

module dtcm_responder
    import dtcm_pkg::*;
#(
    parameter int              XLEN        = DTCM_XLEN,
    parameter int              DEPTH_WORDS = 4096,
    parameter int              LATENCY     = 1,
    parameter logic [XLEN-1:0] BASE_ADDR   = 32'h2000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  dcache_req_t cache_req_i,
`ifdef DTCM_PARITY_EN
    input  logic        inject_par_err_i,
`endif
    output dcache_res_t cache_res_o,
    output logic        err_o
);

    localparam int              NB       = XLEN / 8;
    localparam int              AW       = $clog2(DEPTH_WORDS);
    localparam logic [XLEN-1:0] SPAN     = XLEN'(4 * DEPTH_WORDS);
    localparam logic [1:0]      LAT_LOAD = 2'(LATENCY - 1);

    // RESP is the array-access cycle; the response registers it loads are
    // what the requester sees on the following cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_reg;
    logic [1:0]      cnt_reg;
    logic [XLEN-1:0] addr_reg;
    logic            rw_reg;
    mem_size_t       size_reg;
    logic [XLEN-1:0] wdata_in_reg;
    logic            valid_reg;
    logic            ready_reg;
    logic            err_reg;
    logic            zero_reg;
    logic [XLEN-1:0] ram_q_reg;

    logic [XLEN-1:0] mem [DEPTH_WORDS];

    // Address decode and fault classification of the captured request.
    logic [XLEN-1:0] offset;
    logic [AW-1:0]   idx;
    logic            in_range;
    logic            misalign;
    logic            no_size_wr;
    logic            fault;
    logic [NB-1:0]   be;
    logic [XLEN-1:0] wdata;
    logic            we;

    // Out-of-range addresses below BASE_ADDR wrap to huge offsets, so a
    // single unsigned compare covers both ends of the window.
    assign offset   = addr_reg - BASE_ADDR;
    assign in_range = (offset < SPAN);
    assign idx      = offset[AW+1:2];

    // Misalignment applies to reads and writes; an unsized request only
    // faults for writes since reads always return the full word.
    assign misalign   = ((size_reg == HALF) && addr_reg[0]) ||
                        ((size_reg == WORD) && (addr_reg[1:0] != 2'b00));
    assign no_size_wr = rw_reg && (size_reg == NO_SIZE);
    assign fault      = !in_range || misalign || no_size_wr;
    assign we         = (state_reg == RESP) && rw_reg && !fault;

    // Byte enables and lane replication of the right-aligned write data.
    always_comb begin
        be    = '0;
        wdata = wdata_in_reg;
        case (size_reg)
            BYTE: begin
                be    = 4'b0001 << addr_reg[1:0];
                wdata = {4{wdata_in_reg[7:0]}};
            end
            HALF: begin
                be    = 4'b0011 << {addr_reg[1], 1'b0};
                wdata = {2{wdata_in_reg[15:0]}};
            end
            WORD: begin
                be    = 4'b1111;
                wdata = wdata_in_reg;
            end
            default: begin
                be    = '0;
                wdata = wdata_in_reg;
            end
        endcase
    end

`ifdef DTCM_PARITY_EN
    logic [NB-1:0] par_mem [DEPTH_WORDS];
    logic [NB-1:0] par_q_reg;
    logic [NB-1:0] wpar;
    logic [NB-1:0] par_mis;
    logic          parchk_reg;

    // Even parity per lane on write; compare against the stored bit on read.
    for (genvar gi = 0; gi < NB; gi++) begin : g_par
        assign wpar[gi]    = (^wdata[gi*8 +: 8]) ^ inject_par_err_i;
        assign par_mis[gi] = (^ram_q_reg[gi*8 +: 8]) != par_q_reg[gi];
    end

    // Parity array shares the access cycle and index with the data array.
    always_ff @(posedge clk_i) begin
        if (state_reg == RESP) begin
            par_q_reg <= par_mem[idx];
            for (int b = 0; b < NB; b++) begin
                if (we && be[b]) begin
                    par_mem[idx][b] <= wpar[b];
                end
            end
        end
    end
`endif

    // Single-port array: read-first so a write response carries the old word.
    always_ff @(posedge clk_i) begin
        if (state_reg == RESP) begin
            ram_q_reg <= mem[idx];
            for (int b = 0; b < NB; b++) begin
                if (we && be[b]) begin
                    mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // Request FSM with registered valid/ready/err outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg    <= IDLE;
            cnt_reg      <= 2'd0;
            addr_reg     <= '0;
            rw_reg       <= 1'b0;
            size_reg     <= NO_SIZE;
            wdata_in_reg <= '0;
            valid_reg    <= 1'b0;
            ready_reg    <= 1'b1;
            err_reg      <= 1'b0;
            zero_reg     <= 1'b1;
`ifdef DTCM_PARITY_EN
            parchk_reg   <= 1'b0;
`endif
        end else begin
            valid_reg <= 1'b0;
            err_reg   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (cache_req_i.valid && !flush_i) begin
                        addr_reg     <= cache_req_i.addr;
                        rw_reg       <= cache_req_i.rw;
                        size_reg     <= cache_req_i.rw_size;
                        wdata_in_reg <= cache_req_i.data;
                        cnt_reg      <= LAT_LOAD;
                        ready_reg    <= 1'b0;
                        state_reg    <= (LATENCY == 1) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (flush_i) begin
                        state_reg <= IDLE;
                        ready_reg <= 1'b1;
                        cnt_reg   <= 2'd0;
                    end else if (cnt_reg == 2'd1) begin
                        state_reg <= RESP;
                        cnt_reg   <= 2'd0;
                    end else begin
                        cnt_reg <= cnt_reg - 2'd1;
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b1;
                    valid_reg <= 1'b1;
                    err_reg   <= fault;
                    zero_reg  <= fault;
`ifdef DTCM_PARITY_EN
                    parchk_reg <= !rw_reg && !fault;
`endif
                end
                default: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b1;
                end
            endcase
        end
    end

    // Response bus: data only meaningful alongside valid, zeroed on faults.
    always_comb begin
        cache_res_o.valid = valid_reg;
        cache_res_o.ready = ready_reg;
        cache_res_o.data  = (valid_reg && !zero_reg) ? ram_q_reg : '0;
    end

`ifdef DTCM_PARITY_EN
    assign err_o = err_reg | (valid_reg & parchk_reg & (|par_mis));
`else
    assign err_o = err_reg;
`endif

    // The requester's ready and the cacheability hint have no meaning here.
    logic unused_req;
    assign unused_req = ^{cache_req_i.ready, cache_req_i.uncached};

endmodule

// File: tb/tb_dtcm_responder.sv
// tb_dtcm_responder: directed-vector bench for dtcm_responder.
// Two instances (LATENCY 1 and 3) share one clock. Stimulus pushes expected
// responses into per-instance queues; negedge monitors pop and compare.
// A response is due in the cycle that the requester samples on edge
// accept+LATENCY+1, i.e. the monitor sees it when cyc == accept + LATENCY.
module tb_dtcm_responder;
    import dtcm_pkg::*;

    localparam int          L_A  = 1;
    localparam int          L_B  = 3;
    localparam logic [31:0] BASE = 32'h2000_0000;

    typedef struct {
        logic [31:0] data;
        bit          chk;
        bit          err;
        int          due;
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_a_n, rst_b_n;
    logic        flush_a, flush_b;
    dcache_req_t req_a, req_b;
    dcache_res_t res_a, res_b;
    logic        err_a, err_b;
`ifdef DTCM_PARITY_EN
    logic        inj_a, inj_b;
`endif

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dtcm_responder #(.LATENCY(L_A)) u_a (
        .clk_i            (clk),
        .rst_ni           (rst_a_n),
        .flush_i          (flush_a),
        .cache_req_i      (req_a),
`ifdef DTCM_PARITY_EN
        .inject_par_err_i (inj_a),
`endif
        .cache_res_o      (res_a),
        .err_o            (err_a)
    );

    dtcm_responder #(.LATENCY(L_B)) u_b (
        .clk_i            (clk),
        .rst_ni           (rst_b_n),
        .flush_i          (flush_b),
        .cache_req_i      (req_b),
`ifdef DTCM_PARITY_EN
        .inject_par_err_i (inj_b),
`endif
        .cache_res_o      (res_b),
        .err_o            (err_b)
    );

    function automatic void check_bit(input string name, input logic act, input logic req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %b, required %b", name, act, req);
        end
    endfunction

    function automatic void check_word(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endfunction

    function automatic void cmp_rsp(input string dut, input exp_t e, input logic [31:0] d, input logic er);
        bit ok;
        ok = (cyc == e.due) && (er === e.err) && (!e.chk || (d === e.data));
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s %s: cycle=%0d data=%h err=%b, required cycle=%0d data=%h(chk=%0d) err=%b",
                     dut, e.tag, cyc, d, er, e.due, e.data, e.chk, e.err);
        end else begin
            $display("RSP  %s %s: cycle=%0d data=%h err=%b", dut, e.tag, cyc, d, er);
        end
    endfunction

    // Monitor for the LATENCY=1 instance.
    always @(negedge clk) begin
        if (res_a.valid === 1'b1) begin
            if (q_a.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL u_a unexpected response: data=%h err=%b, required no response", res_a.data, err_a);
            end else begin
                cmp_rsp("u_a", q_a.pop_front(), res_a.data, err_a);
            end
        end else if (err_a !== 1'b0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL u_a err_without_valid: err=%b, required 0", err_a);
        end
    end

    // Monitor for the LATENCY=3 instance.
    always @(negedge clk) begin
        if (res_b.valid === 1'b1) begin
            if (q_b.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL u_b unexpected response: data=%h err=%b, required no response", res_b.data, err_b);
            end else begin
                cmp_rsp("u_b", q_b.pop_front(), res_b.data, err_b);
            end
        end else if (err_b !== 1'b0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL u_b err_without_valid: err=%b, required 0", err_b);
        end
    end

    // Present one request, wait for acceptance, and queue its expected response.
    task automatic issue(input bit use_b, input string tag, input bit rw, input mem_size_t sz,
                         input logic [31:0] addr, input logic [31:0] wd, input bit want,
                         input bit chk, input logic [31:0] xd, input bit xe);
        dcache_req_t r;
        bit          rdy;
        bit          acc;
        exp_t        e;
        r          = '0;
        r.valid    = 1'b1;
        r.addr     = addr;
        r.rw       = rw;
        r.rw_size  = sz;
        r.data     = wd;
        r.uncached = 1'b1;
        if (use_b) req_b = r; else req_a = r;
        acc = 1'b0;
        rdy = 1'b0;
        for (int i = 0; i < 40 && !acc; i++) begin
            @(negedge clk);
            rdy = use_b ? res_b.ready : res_a.ready;
            @(posedge clk);
            acc = rdy;
        end
        #1;
        if (use_b) req_b.valid = 1'b0; else req_a.valid = 1'b0;
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s accept: ready never seen, required ready=1 within 40 cycles", tag);
        end else if (want) begin
            e.data = xd;
            e.chk  = chk;
            e.err  = xe;
            e.tag  = tag;
            e.due  = cyc + (use_b ? L_B : L_A);
            if (use_b) q_b.push_back(e); else q_a.push_back(e);
        end
    endtask

    // Wait (bounded) until every queued response has been seen.
    task automatic wait_done(input bit use_b, input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            done = use_b ? (q_b.size() == 0) : (q_a.size() == 0);
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s timeout: response missing, required one within 40 cycles", tag);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion before 100us");
        $fatal(1, "watchdog");
    end

    initial begin
        req_a   = '0;
        req_b   = '0;
        flush_a = 1'b0;
        flush_b = 1'b0;
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
`ifdef DTCM_PARITY_EN
        inj_a = 1'b0;
        inj_b = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_bit("reset u_a valid", res_a.valid, 1'b0);
        check_bit("reset u_a ready", res_a.ready, 1'b1);
        check_word("reset u_a data", res_a.data, 32'h0);
        check_bit("reset u_a err", err_a, 1'b0);
        check_bit("reset u_b valid", res_b.valid, 1'b0);
        check_bit("reset u_b ready", res_b.ready, 1'b1);
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        @(posedge clk);
        #1;

        // ---------------- LATENCY = 1 ----------------
        issue(0, "a wr word", 1, WORD, BASE + 32'h10, 32'hDEADBEEF, 1, 0, 32'h0, 0);
        wait_done(0, "a wr word");
        issue(0, "a rd word", 0, WORD, BASE + 32'h10, 32'h0, 1, 1, 32'hDEADBEEF, 0);
        wait_done(0, "a rd word");
        issue(0, "a wr byte", 1, BYTE, BASE + 32'h13, 32'h000000A5, 1, 1, 32'hDEADBEEF, 0);
        wait_done(0, "a wr byte");
        issue(0, "a rd merged byte", 0, WORD, BASE + 32'h10, 32'h0, 1, 1, 32'hA5ADBEEF, 0);
        wait_done(0, "a rd merged byte");
        issue(0, "a wr half", 1, HALF, BASE + 32'h12, 32'h00001234, 1, 1, 32'hA5ADBEEF, 0);
        wait_done(0, "a wr half");
        issue(0, "a rd merged half", 0, WORD, BASE + 32'h10, 32'h0, 1, 1, 32'h1234BEEF, 0);
        wait_done(0, "a rd merged half");
        issue(0, "a wr misaligned word", 1, WORD, BASE + 32'h12, 32'h55555555, 1, 1, 32'h0, 1);
        wait_done(0, "a wr misaligned word");
        issue(0, "a rd after misaligned", 0, WORD, BASE + 32'h10, 32'h0, 1, 1, 32'h1234BEEF, 0);
        wait_done(0, "a rd after misaligned");
        issue(0, "a rd below base", 0, WORD, 32'h1FFF_FFFC, 32'h0, 1, 1, 32'h0, 1);
        wait_done(0, "a rd below base");
        issue(0, "a wr last word", 1, WORD, BASE + 32'h3FFC, 32'h0BADF00D, 1, 0, 32'h0, 0);
        wait_done(0, "a wr last word");
        issue(0, "a rd last word", 0, WORD, BASE + 32'h3FFC, 32'h0, 1, 1, 32'h0BADF00D, 0);
        wait_done(0, "a rd last word");
        issue(0, "a rd past end", 0, WORD, BASE + 32'h4000, 32'h0, 1, 1, 32'h0, 1);
        wait_done(0, "a rd past end");
        issue(0, "a wr no_size", 1, NO_SIZE, BASE + 32'h10, 32'h77777777, 1, 1, 32'h0, 1);
        wait_done(0, "a wr no_size");
        issue(0, "a rd misaligned half", 0, HALF, BASE + 32'h11, 32'h0, 1, 1, 32'h0, 1);
        wait_done(0, "a rd misaligned half");
        issue(0, "a rd byte full word", 0, BYTE, BASE + 32'h13, 32'h0, 1, 1, 32'h1234BEEF, 0);
        issue(0, "a rd back-to-back", 0, WORD, BASE + 32'h3FFC, 32'h0, 1, 1, 32'h0BADF00D, 0);
        wait_done(0, "a back-to-back");

`ifdef DTCM_PARITY_EN
        inj_a = 1'b1;
        issue(0, "a wr parity inject", 1, WORD, BASE + 32'h20, 32'hCAFEF00D, 1, 0, 32'h0, 0);
        wait_done(0, "a wr parity inject");
        inj_a = 1'b0;
        issue(0, "a rd parity error", 0, WORD, BASE + 32'h20, 32'h0, 1, 1, 32'hCAFEF00D, 1);
        wait_done(0, "a rd parity error");
        issue(0, "a wr parity clean", 1, WORD, BASE + 32'h20, 32'hCAFEF00D, 1, 1, 32'hCAFEF00D, 0);
        wait_done(0, "a wr parity clean");
        issue(0, "a rd parity clean", 0, WORD, BASE + 32'h20, 32'h0, 1, 1, 32'hCAFEF00D, 0);
        wait_done(0, "a rd parity clean");
`endif

        // ---------------- LATENCY = 3 ----------------
        issue(1, "b wr word", 1, WORD, BASE + 32'h10, 32'hDEADBEEF, 1, 0, 32'h0, 0);
        wait_done(1, "b wr word");
        issue(1, "b wr half", 1, HALF, BASE + 32'h12, 32'h00001234, 1, 1, 32'hDEADBEEF, 0);
        for (int k = 0; k < L_B; k++) begin
            @(negedge clk);
            check_bit("b ready low while busy", res_b.ready, 1'b0);
        end
        @(negedge clk);
        check_bit("b ready high with response", res_b.ready, 1'b1);
        wait_done(1, "b wr half");
        issue(1, "b rd merged half", 0, WORD, BASE + 32'h10, 32'h0, 1, 1, 32'h1234BEEF, 0);
        wait_done(1, "b rd merged half");

        // Flush during WAIT: dropped write, ready back on the following cycle.
        issue(1, "b wr flushed", 1, WORD, BASE + 32'h10, 32'h11111111, 0, 0, 32'h0, 0);
        flush_b = 1'b1;
        @(posedge clk);
        #1;
        flush_b = 1'b0;
        @(negedge clk);
        check_bit("b ready after flush", res_b.ready, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        issue(1, "b rd after flush", 0, WORD, BASE + 32'h10, 32'h0, 1, 1, 32'h1234BEEF, 0);
        wait_done(1, "b rd after flush");

        // Flush coincident with a request in IDLE: not accepted.
        req_b         = '0;
        req_b.valid   = 1'b1;
        req_b.rw      = 1'b1;
        req_b.rw_size = WORD;
        req_b.addr    = BASE + 32'h10;
        req_b.data    = 32'h44444444;
        flush_b       = 1'b1;
        @(posedge clk);
        #1;
        req_b.valid = 1'b0;
        flush_b     = 1'b0;
        @(negedge clk);
        check_bit("b ready after flushed accept", res_b.ready, 1'b1);
        repeat (5) @(posedge clk);
        #1;

        // A request held during WAIT is dropped, not queued.
        issue(1, "b rd busy", 0, WORD, BASE + 32'h10, 32'h0, 1, 1, 32'h1234BEEF, 0);
        req_b         = '0;
        req_b.valid   = 1'b1;
        req_b.rw      = 1'b1;
        req_b.rw_size = WORD;
        req_b.addr    = BASE + 32'h10;
        req_b.data    = 32'h22222222;
        @(negedge clk);
        check_bit("b ready busy 1", res_b.ready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check_bit("b ready busy 2", res_b.ready, 1'b0);
        @(posedge clk);
        #1;
        req_b.valid = 1'b0;
        wait_done(1, "b rd busy");
        repeat (4) @(posedge clk);
        #1;
        issue(1, "b rd after busy drop", 0, WORD, BASE + 32'h10, 32'h0, 1, 1, 32'h1234BEEF, 0);
        wait_done(1, "b rd after busy drop");

        // Asynchronous reset in WAIT: outputs at reset values at once.
        issue(1, "b wr reset", 1, WORD, BASE + 32'h10, 32'h33333333, 0, 0, 32'h0, 0);
        @(posedge clk);
        #1;
        rst_b_n = 1'b0;
        #1;
        check_bit("b valid in reset", res_b.valid, 1'b0);
        check_bit("b ready in reset", res_b.ready, 1'b1);
        @(negedge clk);
        rst_b_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        issue(1, "b rd after reset", 0, WORD, BASE + 32'h10, 32'h0, 1, 1, 32'h1234BEEF, 0);
        wait_done(1, "b rd after reset");

        repeat (5) @(posedge clk);
        check_word("u_a queue drained", 32'(q_a.size()), 32'h0);
        check_word("u_b queue drained", 32'(q_b.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dtcm_responder.md
Name: dtcm_responder

Overview:
- Responder end of the memory-stage data request protocol.
- Accepts dcache_req_t requests and returns dcache_res_t responses.
- Backs them with a single-port, word-organised tightly-coupled data memory, so it can stand in for the dcache on a scratchpad address region.
- Performs sub-word writes from rw_size/addr, returns whole aligned words on reads, and reports misaligned or out-of-range accesses.

Parameters:
- XLEN, 32, data and address width.
- DEPTH_WORDS, 4096, memory depth in XLEN words; must be a power of two.
- LATENCY, 1, cycles from request acceptance to the response pulse; legal range 1..4.
- BASE_ADDR, 32'h2000_0000, first byte address of the region.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset: asynchronous, active-low.
- flush_i  in  1  abort the pending transaction; no response is issued for it.
- cache_req_i  in  dcache_req_t  request: valid, addr, ready, rw (1 = write), rw_size, data, uncached.
- cache_res_o  out  dcache_res_t  response: valid, ready, data.
- err_o  out  1  one-cycle pulse, coincident with cache_res_o.valid, for a faulting access.

Behaviour:
- Reset values:
  - FSM in IDLE; latency counter 0.
  - cache_res_o.valid = 0, cache_res_o.ready = 1, cache_res_o.data = 0, err_o = 0.
  - Memory contents are not reset.
- FSM states:
  - IDLE -> WAIT when cache_req_i.valid is 1 in IDLE (accept).
    - On accept, capture addr, rw, rw_size, data; load counter = LATENCY-1.
    - If LATENCY == 1, go directly IDLE -> RESP.
  - WAIT: decrement the counter each cycle; go to RESP when the counter reaches 0.
  - RESP: drive cache_res_o.valid = 1 for exactly one cycle, then return to IDLE.
  - Back-to-back: a request presented in the RESP cycle is NOT accepted; it is accepted the next cycle (IDLE).
- cache_res_o.ready:
  - 1 only in IDLE.
  - Requests whose valid is high outside IDLE are ignored, not queued; the requester must hold its own in-flight flag.
- Latency: response valid exactly LATENCY+1 cycles after the accepting edge (LATENCY=1 gives the response 2 cycles later, counted from the clock edge where valid was sampled).
- Array access:
  - The memory read or write happens on the edge entering RESP.
  - Read data is registered and presented with valid.
- Indexing: index = (addr - BASE_ADDR) >> 2, taken modulo DEPTH_WORDS.
- Out of range: an address outside [BASE_ADDR, BASE_ADDR + 4*DEPTH_WORDS) sets err.
  - The write is suppressed.
  - Read data = 0.
- Write byte enables:
  - BYTE: 4'b0001 << addr[1:0].
  - HALF: 4'b0011 << {addr[1],1'b0}.
  - WORD: 4'b1111.
  - NO_SIZE: 0, and sets err.
- Write data arrives right-aligned; the responder replicates it:
  - BYTE: {4{data[7:0]}}.
  - HALF: {2{data[15:0]}}.
  - WORD: data unchanged.
- Misalignment:
  - HALF with addr[0]=1, or WORD with addr[1:0]!=0, sets err.
  - The write is suppressed; read data = 0.
- Reads: return the full aligned word regardless of rw_size; the requester does byte/half extraction and sign extension.
- Write response: cache_res_o.valid pulses in RESP; data = the pre-write word content (informational).
- err_o: asserted only in the RESP cycle.
- flush_i:
  - In WAIT: return to IDLE next cycle; the pending write is dropped; no valid, no err.
  - Coincident with an accept in IDLE: the request is not accepted.
  - In RESP: the response still completes; the array is already updated.
- uncached field: ignored (TCM is never cached).
- Asynchronous reset mid-transaction: immediate return to IDLE, outputs at reset values, no response.

Optional Feature:
- DTCM_PARITY_EN defined:
  - One even-parity bit is stored per byte lane, written with that lane's data.
  - On a read, any lane parity mismatch asserts err_o with the response; data is still returned unmodified.
  - A test-only input inject_par_err_i (1 bit) inverts the stored parity of lanes written while it is high.
- DTCM_PARITY_EN undefined:
  - No parity storage and no inject_par_err_i port.
  - err_o covers only misaligned, out-of-range and NO_SIZE faults.

Test Plan:
- Word round trip: LATENCY=1; write WORD 0xDEADBEEF @0x2000_0010 -> valid 2 cycles after accept; then read @0x2000_0010 -> data 0xDEADBEEF, err_o=0.
- Byte merge: after the above, write BYTE data=0x000000A5 @0x2000_0013 -> read @0x2000_0010 returns 0xA5ADBEEF.
- Half merge, LATENCY=3: write HALF 0x1234 @0x2000_0012 -> valid 4 cycles after accept; ready=0 throughout WAIT; read returns 0x1234BEEF.
- Faults:
  - WORD write @0x2000_0012 -> err_o=1 with valid, memory unchanged.
  - Read @0x1FFF_FFFC -> err_o=1, data 0.
- Flush: LATENCY=3, write accepted, flush_i pulsed on the next cycle -> no valid, no err, memory unchanged, ready=1 the following cycle.
- Busy drop and reset: a request held valid during WAIT is ignored; rst_ni low during WAIT -> valid=0, ready=1 immediately.
- Parity (DTCM_PARITY_EN): write with inject_par_err_i=1 then read -> err_o=1.
